gf180mcu_ocd_io__seg_seq: RTL and testbench
===========================================

# gf180mcu_ocd_io__seg_seq

Parametrised power-up sequencer for the pad ring. It switches NSEG pad-ring segment enables on one at a time, in ascending order, with at least STEP_CYC clocks between any two enable edges, to limit inrush current. It switches them off in reverse order with the same spacing. It sits beside the ring filler/supply cells; it carries the same four supply pins for netlist consistency, and its logic runs in the VDD core domain.

## Interface
- NSEG, default 8: number of segment enables, 1..32.
- STEP_CYC, default 16: minimum clocks between successive SEG_EN edges, ≥1.
- CLK  input  1  core clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  level request: 1 = power ring up, 0 = power down.
- FAULT  input  1  level; forces immediate all-off and lockout.
- SEG_EN  output  NSEG  segment enables; bit i = segment i.
- NUM_ON  output  $clog2(NSEG+1)  count of asserted SEG_EN bits.
- READY  output  1  all segments on and settled.
- BUSY  output  1  sequencing in progress (state UP or DOWN).
- LOCKED  output  1  fault lockout active.
- DVDD, DVSS, VDD, VSS  inout  1  supply pins; no logic attached.

## Operation
- States: OFF, UP, ON, DOWN, LOCK. Internal registers: cnt (step timer) and n (equal to NUM_ON).
- Action edge: the edge on which a SEG_EN bit changes. cnt clears to 0 on an action edge and increments on every other edge in UP/DOWN. A timed action fires on the edge where the pre-edge cnt == STEP_CYC-1.
- OFF, EN=1: on the same edge set SEG_EN[0], n=1, cnt=0, go to UP.
- UP, EN=1, n<NSEG: timed action sets SEG_EN[n], n++.
- UP, EN=1, n==NSEG: on the timed edge go to ON and set READY=1. No SEG_EN change.
- UP, EN=0: go to DOWN with no SEG_EN change. cnt keeps counting, so the next clear honours the spacing.
- ON, EN=0: on the same edge clear READY and SEG_EN[NSEG-1], n--, cnt=0, go to DOWN. If NSEG==1, go to OFF.
- DOWN, EN=0: timed action clears SEG_EN[n-1], n--. When n reaches 0, go to OFF on the same edge.
- DOWN, EN=1: go to UP. cnt keeps counting and the next timed action sets SEG_EN[n].
- FAULT=1 in any state except LOCK: next edge SEG_EN=0, n=0, READY=0, BUSY=0, LOCKED=1, go to LOCK.
- LOCK: hold all-off. Leave to OFF (LOCKED=0) on the first edge with FAULT=0 and EN=0.
- Priority per edge: RST > FAULT > EN-driven transitions.
- Invariant: SEG_EN is always a thermometer code (bits 0..n-1 set). Any two SEG_EN edges are ≥STEP_CYC clocks apart, except the simultaneous clear forced by FAULT.
- BUSY = (state==UP || state==DOWN). NUM_ON = n. Both are registered.

## Timing
- Reset values: SEG_EN=0, NUM_ON=0, READY=0, BUSY=0, LOCKED=0, state OFF, cnt=0.
- RST mid-sequence gives the reset values on the next edge; nothing is retained.
- With EN first sampled high at edge 0 from OFF: SEG_EN[i] rises at edge i·STEP_CYC. READY rises at edge NSEG·STEP_CYC.
- With EN first sampled low at edge k from ON: SEG_EN[NSEG-1-i] falls at edge k+i·STEP_CYC. BUSY falls at edge k+(NSEG-1)·STEP_CYC.
- STEP_CYC=1 gives one segment change per clock.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package gf180mcu_ocd_io__seq_pkg holds the state enum (OFF, UP, ON, DOWN, LOCK) and a helper function for the width of NUM_ON.
- Sub-module gf180mcu_ocd_io__step_tmr: the cnt counter with clear/enable inputs and a terminal flag (cnt==STEP_CYC-1), parametrised by STEP_CYC.
- Top level holds the FSM, n, and the SEG_EN/READY registers.

## Test plan
NSEG=4, STEP_CYC=3 unless noted.
- Reset: RST high for 2 edges while EN=1 -> SEG_EN=0000, READY=0, BUSY=0, LOCKED=0; sequencing starts at the first edge after RST falls.
- Power-up: EN high from edge 0 -> SEG_EN=0001@0, 0011@3, 0111@6, 1111@9, READY=1@12, BUSY 1→0@12.
- Power-down: EN falls, sampled at edge 20 -> READY=0 and SEG_EN=0111@20, 0011@23, 0001@26, 0000@29; state OFF@29.
- Abort: EN high @0, low @4 -> SEG_EN 0011@3, 0001@6, 0000@9; no edge closer than 3 clocks. EN re-raised @7 -> next set 0011@9.
- Fault: FAULT=1 while in ON -> next edge SEG_EN=0000, READY=0, LOCKED=1. Holding EN=1 stays in LOCK. EN=0 with FAULT=0 -> OFF, LOCKED=0. EN=1 then re-sequences from 0001.
- Corners: NSEG=1, STEP_CYC=1 -> SEG_EN=1@0, READY@1, and on EN drop SEG_EN=0 with state OFF on the same edge. NSEG=32 sweep: assert the thermometer invariant every cycle.

Source files
------------

// File: rtl/gf180mcu_ocd_io__seq_pkg.sv
// Shared types for the pad-ring segment sequencer: FSM state encoding and
// the NUM_ON width helper.
package gf180mcu_ocd_io__seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_UP   = 3'd1,
    ST_ON   = 3'd2,
    ST_DOWN = 3'd3,
    ST_LOCK = 3'd4
  } seq_state_e;

  function automatic int num_on_w(input int nseg);
    return $clog2(nseg + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__step_tmr.sv
// Step timer: counts clocks since the last SEG_EN edge; term marks STEP_CYC-1.
// One-cycle register latency; saturates at term so spacing is never lost on a wrap.
module gf180mcu_ocd_io__step_tmr #(
  parameter int STEP_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

  logic [CW-1:0] cnt;

  assign term = (cnt == CW'(STEP_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !term) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gf180mcu_ocd_io__seg_seq.sv
// Pad-ring power-up sequencer: enables NSEG segments one per STEP_CYC clocks, up
// in ascending order and down in reverse; FAULT drops all at once. All outputs registered.
module gf180mcu_ocd_io__seg_seq
  import gf180mcu_ocd_io__seq_pkg::*;
#(
  parameter int NSEG     = 8,
  parameter int STEP_CYC = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        EN,
  input  logic                        FAULT,
  output logic [NSEG-1:0]             SEG_EN,
  output logic [num_on_w(NSEG)-1:0]   NUM_ON,
  output logic                        READY,
  output logic                        BUSY,
  output logic                        LOCKED,
  inout  wire                         DVDD,
  inout  wire                         DVSS,
  inout  wire                         VDD,
  inout  wire                         VSS
);

  localparam int NW = num_on_w(NSEG);

  seq_state_e    state, state_nxt;
  logic [NW-1:0] n, n_nxt;
  logic [NSEG-1:0] seg_nxt;
  logic          ready_nxt;
  logic          tmr_clr, tmr_inc, term;

  // Supply pins exist only for netlist consistency with the ring cells.
  wire unused_supply = ^{DVDD, DVSS, VDD, VSS};

  gf180mcu_ocd_io__step_tmr #(.STEP_CYC(STEP_CYC)) u_tmr (
    .clk  (CLK),
    .rst  (RST),
    .clr  (tmr_clr),
    .inc  (tmr_inc),
    .term (term)
  );

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    ready_nxt = READY;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    if (FAULT && state != ST_LOCK) begin
      state_nxt = ST_LOCK;
      n_nxt     = '0;
      ready_nxt = 1'b0;
      tmr_clr   = 1'b1;
    end else begin
      case (state)
        ST_OFF: if (EN) begin
          state_nxt = ST_UP;
          n_nxt     = NW'(1);
          tmr_clr   = 1'b1;
        end
        ST_UP: if (!EN) begin
          state_nxt = ST_DOWN;
          tmr_inc   = 1'b1;
        end else if (term) begin
          if (n == NW'(NSEG)) begin
            state_nxt = ST_ON;
            ready_nxt = 1'b1;
          end else begin
            n_nxt   = n + NW'(1);
            tmr_clr = 1'b1;
          end
        end else begin
          tmr_inc = 1'b1;
        end
        ST_ON: if (!EN) begin
          ready_nxt = 1'b0;
          n_nxt     = n - NW'(1);
          tmr_clr   = 1'b1;
          state_nxt = (n == NW'(1)) ? ST_OFF : ST_DOWN;
        end
        ST_DOWN: if (EN) begin
          state_nxt = ST_UP;
          tmr_inc   = 1'b1;
        end else if (term) begin
          n_nxt     = n - NW'(1);
          tmr_clr   = 1'b1;
          if (n == NW'(1)) state_nxt = ST_OFF;
        end else begin
          tmr_inc = 1'b1;
        end
        ST_LOCK: if (!FAULT && !EN) state_nxt = ST_OFF;
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  // SEG_EN is rebuilt from the next count, so it is a thermometer code by construction.
  always_comb begin
    seg_nxt = '0;
    for (int i = 0; i < NSEG; i++) seg_nxt[i] = (i < int'(n_nxt));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_OFF;
      n      <= '0;
      SEG_EN <= '0;
      READY  <= 1'b0;
      BUSY   <= 1'b0;
      LOCKED <= 1'b0;
    end else begin
      state  <= state_nxt;
      n      <= n_nxt;
      SEG_EN <= seg_nxt;
      READY  <= ready_nxt;
      BUSY   <= (state_nxt == ST_UP) || (state_nxt == ST_DOWN);
      LOCKED <= (state_nxt == ST_LOCK);
    end
  end

  assign NUM_ON = n;

endmodule

// File: tb/tb_gf180mcu_ocd_io__seg_seq.sv
// Directed bench: NSEG=4/STEP=3 main instance, NSEG=1/STEP=1 corner, NSEG=32/STEP=2 sweep.
module tb_gf180mcu_ocd_io__seg_seq;
  import gf180mcu_ocd_io__seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en_a, fault_a, en_b, fault_b, en_c, fault_c;
  wire  dvdd = 1'b1;
  wire  dvss = 1'b0;
  wire  vdd  = 1'b1;
  wire  vss  = 1'b0;

  logic [3:0]                seg_a;
  logic [num_on_w(4)-1:0]    num_a;
  logic                      ready_a, busy_a, locked_a;
  logic [0:0]                seg_b;
  logic [num_on_w(1)-1:0]    num_b;
  logic                      ready_b, busy_b, locked_b;
  logic [31:0]               seg_c;
  logic [num_on_w(32)-1:0]   num_c;
  logic                      ready_c, busy_c, locked_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf180mcu_ocd_io__seg_seq #(.NSEG(4), .STEP_CYC(3)) u_a (
    .CLK(clk), .RST(rst), .EN(en_a), .FAULT(fault_a), .SEG_EN(seg_a), .NUM_ON(num_a),
    .READY(ready_a), .BUSY(busy_a), .LOCKED(locked_a),
    .DVDD(dvdd), .DVSS(dvss), .VDD(vdd), .VSS(vss));

  gf180mcu_ocd_io__seg_seq #(.NSEG(1), .STEP_CYC(1)) u_b (
    .CLK(clk), .RST(rst), .EN(en_b), .FAULT(fault_b), .SEG_EN(seg_b), .NUM_ON(num_b),
    .READY(ready_b), .BUSY(busy_b), .LOCKED(locked_b),
    .DVDD(dvdd), .DVSS(dvss), .VDD(vdd), .VSS(vss));

  gf180mcu_ocd_io__seg_seq #(.NSEG(32), .STEP_CYC(2)) u_c (
    .CLK(clk), .RST(rst), .EN(en_c), .FAULT(fault_c), .SEG_EN(seg_c), .NUM_ON(num_c),
    .READY(ready_c), .BUSY(busy_c), .LOCKED(locked_c),
    .DVDD(dvdd), .DVSS(dvss), .VDD(vdd), .VSS(vss));

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] th4(input int k);
    logic [4:0] t;
    t = (5'd1 << k) - 5'd1;
    return t[3:0];
  endfunction

  initial begin
    logic [3:0] abort_exp [10];
    logic [3:0] rerise_exp [19];
    int en_sched [4];
    int len_sched [4];
    int k, cyc, last_chg;
    logic [31:0] prev_seg;

    abort_exp  = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h1, 4'h1, 4'h1, 4'h0};
    rerise_exp = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h1, 4'h1, 4'h1, 4'h3,
                   4'h3, 4'h3, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF};
    en_sched   = '{1, 0, 1, 0};
    len_sched  = '{70, 20, 10, 80};

    rst = 1'b1;
    en_a = 1'b1; fault_a = 1'b0;
    en_b = 1'b0; fault_b = 1'b0;
    en_c = 1'b0; fault_c = 1'b0;

    // Reset held two edges with EN high
    tick(); tick();
    check_vec("rst seg", seg_a, 4'h0);
    check_vec("rst num_on", num_a, 0);
    check_vec("rst ready", ready_a, 0);
    check_vec("rst busy", busy_a, 0);
    check_vec("rst locked", locked_a, 0);
    rst = 1'b0;

    // Power-up from edge 0
    for (int e = 0; e <= 12; e++) begin
      tick();
      k = (e / 3 + 1 > 4) ? 4 : e / 3 + 1;
      check_vec($sformatf("up seg@%0d", e), seg_a, th4(k));
      check_vec($sformatf("up busy@%0d", e), busy_a, (e < 12));
      check_vec($sformatf("up ready@%0d", e), ready_a, (e >= 12));
    end
    for (int e = 13; e <= 19; e++) tick();

    // Power-down, EN sampled low at edge 20
    en_a = 1'b0;
    for (int e = 20; e <= 29; e++) begin
      tick();
      k = 3 - (e - 20) / 3;
      check_vec($sformatf("dn seg@%0d", e), seg_a, th4(k));
      check_vec($sformatf("dn busy@%0d", e), busy_a, (e < 29));
      check_vec($sformatf("dn ready@%0d", e), ready_a, 0);
    end
    check_vec("dn num_on", num_a, 0);
    check_vec("dn locked", locked_a, 0);

    // Abort: EN low at edge 4
    en_a = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      if (e == 4) en_a = 1'b0;
      tick();
      check_vec($sformatf("abort seg@%0d", e), seg_a, abort_exp[e]);
    end
    check_vec("abort busy", busy_a, 0);

    // Abort then EN re-raised at edge 7, run on to ON
    en_a = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      if (e == 4) en_a = 1'b0;
      if (e == 7) en_a = 1'b1;
      tick();
      check_vec($sformatf("rerise seg@%0d", e), seg_a, rerise_exp[e]);
    end
    check_vec("rerise ready", ready_a, 1);

    // Fault from ON
    fault_a = 1'b1;
    tick();
    check_vec("fault seg", seg_a, 4'h0);
    check_vec("fault ready", ready_a, 0);
    check_vec("fault locked", locked_a, 1);
    check_vec("fault busy", busy_a, 0);
    check_vec("fault num_on", num_a, 0);
    fault_a = 1'b0;
    tick(); tick();
    check_vec("lock hold locked", locked_a, 1);
    check_vec("lock hold seg", seg_a, 4'h0);
    en_a = 1'b0;
    tick();
    check_vec("unlock locked", locked_a, 0);
    check_vec("unlock seg", seg_a, 4'h0);
    en_a = 1'b1;
    tick();
    check_vec("reseq seg", seg_a, 4'h1);
    check_vec("reseq busy", busy_a, 1);
    tick(); tick(); tick();
    check_vec("reseq seg@3", seg_a, 4'h3);

    // Reset mid-sequence
    rst = 1'b1;
    tick();
    check_vec("midrst seg", seg_a, 4'h0);
    check_vec("midrst num_on", num_a, 0);
    check_vec("midrst busy", busy_a, 0);
    rst = 1'b0;
    en_a = 1'b0;
    tick();

    // NSEG=1, STEP_CYC=1 corner
    en_b = 1'b1;
    tick();
    check_vec("n1 seg@0", seg_b, 1'b1);
    check_vec("n1 ready@0", ready_b, 0);
    check_vec("n1 busy@0", busy_b, 1);
    tick();
    check_vec("n1 ready@1", ready_b, 1);
    check_vec("n1 busy@1", busy_b, 0);
    en_b = 1'b0;
    tick();
    check_vec("n1 drop seg", seg_b, 1'b0);
    check_vec("n1 drop busy", busy_b, 0);
    check_vec("n1 drop ready", ready_b, 0);
    en_b = 1'b1;
    tick();
    check_vec("n1 reseq seg", seg_b, 1'b1);
    en_b = 1'b0;
    tick();

    // NSEG=32 sweep with thermometer and spacing checks every edge
    cyc = 0;
    last_chg = -100;
    prev_seg = seg_c;
    for (int p = 0; p < 4; p++) begin
      en_c = en_sched[p][0];
      for (int t = 0; t < len_sched[p]; t++) begin
        tick();
        cyc++;
        check_vec($sformatf("sweep therm@%0d", cyc), ((seg_c & (seg_c + 32'd1)) == 32'd0), 1);
        if (seg_c != prev_seg) begin
          check_vec($sformatf("sweep spacing@%0d", cyc), (cyc - last_chg >= 2), 1);
          last_chg = cyc;
          prev_seg = seg_c;
        end
      end
      if (p == 0) begin
        check_vec("sweep full seg", seg_c, 32'hFFFF_FFFF);
        check_vec("sweep full ready", ready_c, 1);
        check_vec("sweep full num_on", num_c, 32);
      end
    end
    check_vec("sweep end seg", seg_c, 32'h0);
    check_vec("sweep end busy", busy_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
